// File: rtl/eif_pkg.sv
// Shared types and default sizes for the AdEx neuron scheduler.
package eif_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_t;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_NUM_NEURONS = 4;

endpackage

// File: rtl/eif_state_mem.sv
// Per-neuron v/w/i/refractory register file: two combinational read ports,
// one write-back port and an independent input-current write port.
module eif_state_mem #(
    parameter int                NUM_NEURONS = 4,
    parameter int                DATA_W      = 8,
    parameter int                IDX_W       = 2,
    parameter int                RW          = 2,
    parameter logic [DATA_W-1:0] V_REST      = 8'd16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_v,
    output logic [DATA_W-1:0] rd_w,
    output logic [DATA_W-1:0] rd_i,
    output logic [RW-1:0]     rd_refrac,
    input  logic [IDX_W-1:0]  sel_idx,
    output logic [DATA_W-1:0] sel_v,
    input  logic              wb_en,
    input  logic [IDX_W-1:0]  wb_idx,
    input  logic [DATA_W-1:0] wb_v,
    input  logic [DATA_W-1:0] wb_w,
    input  logic [RW-1:0]     wb_refrac,
    input  logic              cur_we,
    input  logic [IDX_W-1:0]  cur_idx,
    input  logic [DATA_W-1:0] cur_data
);

    logic [DATA_W-1:0] v_mem [NUM_NEURONS];
    logic [DATA_W-1:0] w_mem [NUM_NEURONS];
    logic [DATA_W-1:0] i_mem [NUM_NEURONS];
    logic [RW-1:0]     r_mem [NUM_NEURONS];

    assign rd_v      = v_mem[rd_idx];
    assign rd_w      = w_mem[rd_idx];
    assign rd_i      = i_mem[rd_idx];
    assign rd_refrac = r_mem[rd_idx];
    assign sel_v     = v_mem[sel_idx];

    // Write-back never touches i, so the two write ports cannot collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
                v_mem[n] <= V_REST;
                w_mem[n] <= '0;
                i_mem[n] <= '0;
                r_mem[n] <= '0;
            end
        end else begin
            if (wb_en) begin
                v_mem[wb_idx] <= wb_v;
                w_mem[wb_idx] <= wb_w;
                r_mem[wb_idx] <= wb_refrac;
            end
            if (cur_we) begin
                i_mem[cur_idx] <= cur_data;
            end
        end
    end

endmodule

// File: rtl/eif_neuron_scheduler.sv
// Sweeps NUM_NEURONS virtual AdEx neurons through one shared datapath per tick.
// Handshake: dp_req holds dp_idx/dp_v/dp_w/dp_i stable until dp_ack is seen high in the same cycle.
module eif_neuron_scheduler
    import eif_pkg::*;
#(
    parameter int                NUM_NEURONS  = DEF_NUM_NEURONS,
    parameter int                DATA_W       = DEF_DATA_W,
    parameter int                IDX_W        = $clog2(NUM_NEURONS),
    parameter int                REFRAC_TICKS = 2,
    parameter logic [DATA_W-1:0] V_REST       = 8'd16,
    parameter logic [DATA_W-1:0] V_RESET      = 8'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              cur_we,
    input  logic [IDX_W-1:0]  cur_idx,
    input  logic [DATA_W-1:0] cur_data,
    output logic              dp_req,
    output logic [IDX_W-1:0]  dp_idx,
    output logic [DATA_W-1:0] dp_v,
    output logic [DATA_W-1:0] dp_w,
    output logic [DATA_W-1:0] dp_i,
    input  logic              dp_ack,
    input  logic [DATA_W-1:0] dp_v_next,
    input  logic [DATA_W-1:0] dp_w_next,
    input  logic              dp_spike,
    output logic              spk_valid,
    output logic [IDX_W-1:0]  spk_idx,
    output logic              busy,
    output logic              overrun,
    input  logic [IDX_W-1:0]  state_sel,
    output logic [DATA_W-1:0] state_v,
    output logic [1:0]        dbg_state
);

    localparam int RW = $clog2(REFRAC_TICKS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    state_t            state, state_nx;
    logic [IDX_W-1:0]  idx, cap_idx;
    logic [DATA_W-1:0] op_v, op_w, op_i, rd_v, rd_w, rd_i;
    logic [DATA_W-1:0] res_v, res_w, wb_v, wb_w;
    logic [RW-1:0]     op_refrac, rd_refrac, wb_refrac;
    logic              res_spike, cap_en, res_en, wb_en, skip;

    assign skip      = (op_refrac != '0);
    assign busy      = (state != IDLE);
    assign dbg_state = state;
    assign dp_idx    = idx;
    assign dp_v      = op_v;
    assign dp_w      = op_w;
    assign dp_i      = op_i;

    always_comb begin
        state_nx = state;
        cap_en   = 1'b0;
        cap_idx  = '0;
        res_en   = 1'b0;
        wb_en    = 1'b0;
        dp_req   = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_nx = ISSUE;
                    cap_en   = 1'b1;
                end
            end
            ISSUE: begin
                if (skip) begin
                    state_nx = WB;
                end else begin
                    dp_req = 1'b1;
                    if (dp_ack) begin
                        res_en   = 1'b1;
                        state_nx = WB;
                    end
                end
            end
            WB: begin
                wb_en = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = ISSUE;
                    cap_en   = 1'b1;
                    cap_idx  = idx + IDX_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // A skipped neuron only counts down its refractory period; a skip implies op_refrac > 0.
    always_comb begin
        wb_v      = res_v;
        wb_w      = res_w;
        wb_refrac = '0;
        if (skip) begin
            wb_v      = op_v;
            wb_w      = op_w;
            wb_refrac = op_refrac - RW'(1);
        end else if (res_spike) begin
            wb_v      = V_RESET;
            wb_refrac = RW'(REFRAC_TICKS);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            op_v      <= '0;
            op_w      <= '0;
            op_i      <= '0;
            op_refrac <= '0;
            res_v     <= '0;
            res_w     <= '0;
            res_spike <= 1'b0;
            spk_valid <= 1'b0;
            spk_idx   <= '0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nx;
            spk_valid <= 1'b0;
            if (cap_en) begin
                idx       <= cap_idx;
                op_v      <= rd_v;
                op_w      <= rd_w;
                op_i      <= rd_i;
                op_refrac <= rd_refrac;
            end
            if (res_en) begin
                res_v     <= dp_v_next;
                res_w     <= dp_w_next;
                res_spike <= dp_spike;
            end
            if (wb_en && !skip && res_spike) begin
                spk_valid <= 1'b1;
                spk_idx   <= idx;
            end
            if (tick && state != IDLE) begin
                overrun <= 1'b1;
            end
        end
    end

    eif_state_mem #(
        .NUM_NEURONS (NUM_NEURONS),
        .DATA_W      (DATA_W),
        .IDX_W       (IDX_W),
        .RW          (RW),
        .V_REST      (V_REST)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (cap_idx),
        .rd_v      (rd_v),
        .rd_w      (rd_w),
        .rd_i      (rd_i),
        .rd_refrac (rd_refrac),
        .sel_idx   (state_sel),
        .sel_v     (state_v),
        .wb_en     (wb_en),
        .wb_idx    (idx),
        .wb_v      (wb_v),
        .wb_w      (wb_w),
        .wb_refrac (wb_refrac),
        .cur_we    (cur_we),
        .cur_idx   (cur_idx),
        .cur_data  (cur_data)
    );

endmodule

// File: tb/tb_eif_neuron_scheduler.sv
// Bench for eif_neuron_scheduler: acts as the AdEx datapath and checks against a per-neuron model.
module tb_eif_neuron_scheduler;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst, tick, cur_we, dp_ack, dp_spike;
    logic [IW-1:0] cur_idx, state_sel;
    logic [W-1:0]  cur_data, dp_v_next, dp_w_next;
    logic          dp_req, spk_valid, busy, overrun;
    logic [IW-1:0] dp_idx, spk_idx;
    logic [W-1:0]  dp_v, dp_w, dp_i, state_v;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    // Behavioural model: neuron-level state after each completed sweep.
    int m_v[N], m_w[N], m_i[N], m_ref[N];

    always #5 clk = ~clk;

    eif_neuron_scheduler dut (
        .clk(clk), .rst(rst), .tick(tick),
        .cur_we(cur_we), .cur_idx(cur_idx), .cur_data(cur_data),
        .dp_req(dp_req), .dp_idx(dp_idx), .dp_v(dp_v), .dp_w(dp_w), .dp_i(dp_i),
        .dp_ack(dp_ack), .dp_v_next(dp_v_next), .dp_w_next(dp_w_next), .dp_spike(dp_spike),
        .spk_valid(spk_valid), .spk_idx(spk_idx), .busy(busy), .overrun(overrun),
        .state_sel(state_sel), .state_v(state_v), .dbg_state(dbg_state)
    );

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; tick = 1'b0; cur_we = 1'b0; dp_ack = 1'b0; dp_spike = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < N; n++) begin
            m_v[n] = 16; m_w[n] = 0; m_i[n] = 0; m_ref[n] = 0;
        end
    endtask

    task automatic load_cur(input int n, input int val);
        @(negedge clk);
        cur_we = 1'b1; cur_idx = IW'(n); cur_data = W'(val);
        m_i[n] = val;
        @(negedge clk);
        cur_we = 1'b0;
    endtask

    // One tick-triggered sweep with ack latency d; optional tick and current-write collisions.
    task automatic run_sweep(input int d, input bit inj_tick, input bit inj_cur);
        int act_q[$];
        int spk_q[$];
        bit skipped[N];
        int exp_busy, busy_cnt, hold, n, nv;
        bit done, cur_done;
        exp_busy = 0; busy_cnt = 0; hold = 0; done = 0; cur_done = 0;
        for (int k = 0; k < N; k++) begin
            skipped[k] = (m_ref[k] != 0);
            if (skipped[k]) exp_busy += 2;
            else begin act_q.push_back(k); exp_busy += d + 2; end
        end
        @(negedge clk);
        tick = 1'b1;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(negedge clk);
            tick = 1'b0; cur_we = 1'b0; dp_ack = 1'b0; dp_spike = $urandom_range(0, 1);
            dp_v_next = W'($urandom); dp_w_next = W'($urandom);
            if (inj_tick && cyc == 3) tick = 1'b1;
            if (spk_valid) begin
                checks++;
                if (spk_q.size() == 0 || int'(spk_idx) != spk_q[0]) begin
                    errors++;
                    $display("FAIL spk_event: spk_idx=%0d expected_pending=%0d", spk_idx, spk_q.size());
                end else void'(spk_q.pop_front());
            end
            if (!busy) done = 1;
            else begin
                busy_cnt++;
                if (dp_req) begin
                    checks++;
                    if (act_q.size() == 0) begin
                        errors++;
                        $display("FAIL dp_req_unexpected: dp_idx=%0d", dp_idx);
                    end else begin
                        n = act_q[0];
                        if (int'(dp_idx) != n || int'(dp_v) != m_v[n] || int'(dp_w) != m_w[n] || int'(dp_i) != m_i[n]) begin
                            errors++;
                            $display("FAIL dp_operands: got idx=%0d v=%0d w=%0d i=%0d want idx=%0d v=%0d w=%0d i=%0d",
                                     dp_idx, dp_v, dp_w, dp_i, n, m_v[n], m_w[n], m_i[n]);
                        end
                        if (inj_cur && !cur_done && n == 0) begin
                            cur_we = 1'b1; cur_idx = 2'd3; cur_data = 8'd5;
                            m_i[3] = 5; cur_done = 1;
                        end
                        if (hold == d) begin
                            nv = (m_v[n] + m_i[n]) % 256;
                            dp_ack = 1'b1; dp_v_next = W'(nv); dp_w_next = W'(m_w[n]);
                            dp_spike = (nv >= 40);
                            if (nv >= 40) begin
                                m_v[n] = 0; m_ref[n] = 2; spk_q.push_back(n);
                            end else m_v[n] = nv;
                            void'(act_q.pop_front());
                            hold = 0;
                        end else hold++;
                    end
                end
            end
        end
        dp_ack = 1'b0;
        for (int k = 0; k < N; k++) if (skipped[k]) m_ref[k]--;
        checks++;
        if (!done || busy_cnt != exp_busy || act_q.size() != 0 || spk_q.size() != 0) begin
            errors++;
            $display("FAIL sweep_shape: busy_cycles=%0d want=%0d ended=%0d unissued=%0d spikes_missing=%0d",
                     busy_cnt, exp_busy, done, act_q.size(), spk_q.size());
        end
        for (int k = 0; k < N; k++) begin
            state_sel = IW'(k);
            #1;
            checks++;
            if (int'(state_v) != m_v[k]) begin
                errors++;
                $display("FAIL state_v[%0d]: got=%0d want=%0d", k, state_v, m_v[k]);
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (busy !== 1'b0 || dp_req !== 1'b0 || overrun !== 1'b0 || spk_valid !== 1'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b dp_req=%b overrun=%b spk_valid=%b state=%0d want all 0",
                     busy, dp_req, overrun, spk_valid, dbg_state);
        end
        checks++;
        if (dp_idx !== 2'd0 || dp_v !== 8'd0 || dp_w !== 8'd0 || dp_i !== 8'd0 || spk_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_operands: idx=%0d v=%0d w=%0d i=%0d spk_idx=%0d want 0",
                     dp_idx, dp_v, dp_w, dp_i, spk_idx);
        end
        for (int k = 0; k < N; k++) begin
            state_sel = IW'(k);
            #1;
            checks++;
            if (state_v !== 8'd16) begin
                errors++;
                $display("FAIL reset_v[%0d]: got=%0d want=16", k, state_v);
            end
        end
    endtask

    task automatic test_basic_sweep();
        for (int k = 0; k < N; k++) load_cur(k, k + 1);
        run_sweep(0, 0, 0);
        state_sel = 2'd2;
        #1;
        checks++;
        if (state_v !== 8'd19) begin
            errors++;
            $display("FAIL basic_v2: got=%0d want=19", state_v);
        end
    endtask

    task automatic test_spike_refrac();
        apply_reset();
        load_cur(0, 1); load_cur(1, 30); load_cur(2, 2); load_cur(3, 3);
        for (int s = 0; s < 4; s++) begin
            run_sweep(0, 0, 0);
            state_sel = 2'd1;
            #1;
            checks++;
            if (int'(state_v) != ((s < 3) ? 0 : 30)) begin
                errors++;
                $display("FAIL refrac_v1_sweep%0d: got=%0d want=%0d", s, state_v, (s < 3) ? 0 : 30);
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        for (int k = 0; k < N; k++) load_cur(k, 2);
        run_sweep(3, 0, 0);
    endtask

    task automatic test_collisions();
        apply_reset();
        for (int k = 0; k < N; k++) load_cur(k, 1);
        run_sweep(0, 1, 1);
        state_sel = 2'd3;
        #1;
        checks++;
        if (overrun !== 1'b1 || state_v !== 8'd21) begin
            errors++;
            $display("FAIL collision: overrun=%b v3=%0d want overrun=1 v3=21", overrun, state_v);
        end
        run_sweep(1, 0, 0);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: got=%b want=1", overrun);
        end
    endtask

    task automatic test_mid_reset();
        bit found;
        found = 0;
        for (int k = 0; k < N; k++) load_cur(k, 3);
        @(negedge clk);
        tick = 1'b1;
        for (int cyc = 0; cyc < 50 && !found; cyc++) begin
            @(negedge clk);
            tick = 1'b0; dp_ack = 1'b0;
            if (dp_req && dp_idx == 2'd2) found = 1;
            else if (dp_req) begin
                dp_ack = 1'b1; dp_v_next = 8'd20; dp_w_next = 8'd0; dp_spike = 1'b0;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_reset_wait: neuron 2 never requested within budget");
        end
        dp_ack = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin m_v[k] = 16; m_w[k] = 0; m_i[k] = 0; m_ref[k] = 0; end
        checks++;
        if (dp_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_ctrl: dp_req=%b busy=%b want 0 0", dp_req, busy);
        end
        repeat (2) @(negedge clk);
        dp_ack = 1'b1; dp_v_next = 8'd99; dp_w_next = 8'd7; dp_spike = 1'b1;
        @(negedge clk);
        dp_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (dp_req !== 1'b0 || busy !== 1'b0 || spk_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack: dp_req=%b busy=%b spk_valid=%b want 0 0 0", dp_req, busy, spk_valid);
        end
        for (int k = 0; k < N; k++) begin
            state_sel = IW'(k);
            #1;
            checks++;
            if (state_v !== 8'd16) begin
                errors++;
                $display("FAIL mid_reset_v[%0d]: got=%0d want=16", k, state_v);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < N; k++) load_cur(k, $urandom_range(0, 15));
        for (int s = 0; s < 8; s++) begin
            if ($urandom_range(0, 1) == 1) load_cur($urandom_range(0, N - 1), $urandom_range(0, 15));
            run_sweep($urandom_range(0, 2), 0, 0);
        end
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; cur_we = 1'b0; cur_idx = '0; cur_data = '0;
        dp_ack = 1'b0; dp_v_next = '0; dp_w_next = '0; dp_spike = 1'b0; state_sel = '0;
        test_reset();
        test_basic_sweep();
        test_spike_refrac();
        test_backpressure();
        test_collisions();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
